piso_shift_ctrl: RTL

Sequencing controller for a parallel-in/serial-out shift datapath. It accepts a parallel word over a valid/ready handshake, loads it into an internal shift register and shifts it out MSB-first. Each bit is held for a programmable number of clock cycles. It frames the transfer with an active flag, a per-bit strobe and a completion pulse. It sits between a CPU-side register/FIFO and a simple serial pin interface (SPI-style MOSI, debug serial, LED chain).

---
 rtl/piso_shift_ctrl_pkg.sv | 7 +
 rtl/bit_period_counter.sv | 18 +
 rtl/piso_shift_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/piso_shift_ctrl_pkg.sv
// piso_shift_ctrl_pkg: shared state encoding and counter width helper for serial controllers
package piso_shift_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bit_period_counter.sv
// bit_period_counter: CLKS_PER_BIT divider (clk, rst_n, clr, en -> cnt, tc at CLKS_PER_BIT-1)
module bit_period_counter
  import piso_shift_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  localparam int DW = cnt_w(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [DW-1:0] cnt,
  output logic          tc
);
  assign tc = cnt == DW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    cnt <= (!rst_n || clr) ? '0 : en ? (tc ? '0 : cnt + DW'(1)) : cnt;
endmodule

// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl: valid/ready word in, MSB-first serial out with active/strobe/done framing
module piso_shift_ctrl
  import piso_shift_ctrl_pkg::*;
#(
  parameter int   WIDTH        = 8,
  parameter int   CLKS_PER_BIT = 4,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_active,
  output logic             bit_strobe,
  output logic             done
);
  localparam int BW = cnt_w(WIDTH);
  localparam int DW = cnt_w(CLKS_PER_BIT);
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             tc;
  bit_period_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_SHIFT),
    .en    (state == ST_SHIFT),
    .cnt   (div_cnt),
    .tc    (tc)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          state   <= ST_SHIFT;
          shreg   <= in_data;
          bit_cnt <= '0;
        end
        ST_SHIFT: if (abort) state <= ST_IDLE;
        else if (tc) begin
          if (bit_cnt == BW'(WIDTH - 1)) state <= ST_DONE;
          else begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign in_ready   = state == ST_IDLE;
  assign ser_active = state == ST_SHIFT;
  assign ser_out    = ser_active ? shreg[WIDTH-1] : IDLE_LEVEL;
  assign bit_strobe = ser_active && div_cnt == '0;
  assign done       = state == ST_DONE;
endmodule
